// File: rtl/step_clk_pkg.sv
// Shared definitions for the step/run clock-enable controller:
// mode encodings, FSM state type, counter width helper and parameter range check.
package step_clk_pkg;

  localparam logic MODE_STEP = 1'b0;
  localparam logic MODE_RUN  = 1'b1;

  // FSM states share the encoding of the synchronised mode input
  typedef enum logic {
    ST_STEP = MODE_STEP,
    ST_RUN  = MODE_RUN
  } clk_state_t;

  // Bits needed to hold values 0..max_val, never less than one bit
  function automatic int width_for(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

  // Every count-type parameter of this block must be at least one
  function automatic bit param_ok(input int value);
    return (value >= 1);
  endfunction

endpackage

// File: rtl/step_clk_ctrl_debounce.sv
// One button channel: two-flop synchroniser, stability counter,
// debounced level and one-cycle rise/fall pulses.
// rise_next is the combinational "a rise is being accepted this edge" term,
// so a neighbour can register a pulse aligned with rise.
module btn_debounce
  import step_clk_pkg::*;
#(
  parameter int STABLE_CYCLES = 16
) (
  input  logic clk,
  input  logic res,
  input  logic button,
  output logic level,
  output logic rise,
  output logic fall,
  output logic rise_next
);

  localparam int               CNT_W    = width_for(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  assign accept    = (sync2 != level) && (cnt == CNT_LAST);
  assign rise_next = accept && sync2;

  // Bring the asynchronous pin into the clock domain before anything looks at it
  always_ff @(posedge clk) begin
    if (!res) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after it has differed from the current one long enough
  always_ff @(posedge clk) begin
    if (!res) begin
      level <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (accept) begin
        level <= sync2;
        cnt   <= '0;
        rise  <= sync2;
        fall  <= !sync2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/step_clk_ctrl.sv
// Multi-channel push-button conditioner and CPU clock-enable source.
// Channel 0 drives clk_en: one pulse per press in STEP mode, a free-running
// divider in RUN mode. Define AUTO_REPEAT_EN to add hold-to-repeat in STEP mode.
module step_clk_ctrl
  import step_clk_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int STABLE_CYCLES = 16,
  parameter int RUN_DIV       = 4,
  parameter int REPEAT_DELAY  = 1024,
  parameter int REPEAT_PERIOD = 256
) (
  input  logic                clk,
  input  logic                res,
  input  logic [CHANNELS-1:0] button,
  input  logic                mode,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                clk_en
);

  if (!param_ok(CHANNELS))      begin : g_chk_channels $error("CHANNELS must be >= 1");      end
  if (!param_ok(STABLE_CYCLES)) begin : g_chk_stable   $error("STABLE_CYCLES must be >= 1"); end
  if (!param_ok(RUN_DIV))       begin : g_chk_div      $error("RUN_DIV must be >= 1");       end
  if (!param_ok(REPEAT_DELAY))  begin : g_chk_delay    $error("REPEAT_DELAY must be >= 1");  end
  if (!param_ok(REPEAT_PERIOD)) begin : g_chk_period   $error("REPEAT_PERIOD must be >= 1"); end

  localparam int               DIV_W    = width_for(RUN_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

  logic [CHANNELS-1:0] rise_next;
  logic                unused_rise_next;
  clk_state_t          state;
  logic                mode_s1;
  logic                mode_s2;
  logic [DIV_W-1:0]    div;
  logic [DIV_W-1:0]    div_next;
  logic                mode_change;
  logic                rep_fire;

  assign unused_rise_next = ^rise_next;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    btn_debounce #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_debounce (
      .clk      (clk),
      .res      (res),
      .button   (button[g]),
      .level    (level[g]),
      .rise     (rise[g]),
      .fall     (fall[g]),
      .rise_next(rise_next[g])
    );
  end

  assign mode_change = (clk_state_t'(mode_s2) != state);
  assign div_next    = (div == DIV_LAST) ? '0 : div + DIV_W'(1);

`ifdef AUTO_REPEAT_EN
  localparam int               REP_MAX        = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int               REP_W          = width_for(REP_MAX);
  localparam logic [REP_W-1:0] REP_DELAY_LAST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_PER_LAST   = REP_W'(REPEAT_PERIOD - 1);

  logic [REP_W-1:0] rep_cnt;
  logic             rep_periodic;

  assign rep_fire = (state == ST_STEP) && !mode_change && level[0] &&
                    (rep_cnt == (rep_periodic ? REP_PER_LAST : REP_DELAY_LAST));

  // Time how long channel 0 has been held; counting starts on the rise cycle
  always_ff @(posedge clk) begin
    if (!res) begin
      rep_cnt      <= '0;
      rep_periodic <= 1'b0;
    end else if (mode_change || (state != ST_STEP) || !level[0]) begin
      rep_cnt      <= '0;
      rep_periodic <= 1'b0;
    end else if (rep_fire) begin
      rep_cnt      <= '0;
      rep_periodic <= 1'b1;
    end else begin
      rep_cnt <= rep_cnt + REP_W'(1);
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  // Mode synchroniser plus STEP/RUN state machine producing the registered clock enable
  always_ff @(posedge clk) begin
    if (!res) begin
      mode_s1 <= 1'b0;
      mode_s2 <= 1'b0;
      state   <= ST_STEP;
      div     <= '0;
      clk_en  <= 1'b0;
    end else begin
      mode_s1 <= mode;
      mode_s2 <= mode_s1;
      if (mode_change) begin
        state  <= clk_state_t'(mode_s2);
        div    <= '0;
        clk_en <= 1'b0;
      end else if (state == ST_RUN) begin
        div    <= div_next;
        clk_en <= (div_next == DIV_LAST);
      end else begin
        div    <= '0;
        clk_en <= rise_next[0] || rep_fire;
      end
    end
  end

endmodule

// File: tb/tb_step_clk_ctrl.sv
// Directed self-checking bench for step_clk_ctrl with CHANNELS=2, STABLE_CYCLES=8,
// RUN_DIV=4, REPEAT_DELAY=32, REPEAT_PERIOD=8. Honours AUTO_REPEAT_EN if defined.
// Expected output vectors are {level, rise, fall, clk_en}.
module tb_step_clk_ctrl;

`ifdef AUTO_REPEAT_EN
  localparam bit REPEAT_ON = 1'b1;
`else
  localparam bit REPEAT_ON = 1'b0;
`endif

  logic       clk;
  logic       res;
  logic [1:0] button;
  logic       mode;
  logic [1:0] level;
  logic [1:0] rise;
  logic [1:0] fall;
  logic       clk_en;

  typedef struct {
    string      tag;
    logic [6:0] vec;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  step_clk_ctrl #(
    .CHANNELS     (2),
    .STABLE_CYCLES(8),
    .RUN_DIV      (4),
    .REPEAT_DELAY (32),
    .REPEAT_PERIOD(8)
  ) dut (
    .clk   (clk),
    .res   (res),
    .button(button),
    .mode  (mode),
    .level (level),
    .rise  (rise),
    .fall  (fall),
    .clk_en(clk_en)
  );

  // Free-running clock, posedges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence never completes
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic [1:0] b, input logic m, input logic r);
    button = b;
    mode   = m;
    res    = r;
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pushExpect(input string tag, input logic [6:0] vec);
    exp_t e;
    e.tag = tag;
    e.vec = vec;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t       e;
    logic [6:0] obs;
    obs = {level, rise, fall, clk_en};
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("[TB] FAIL scoreboard_empty: observed %b expected none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.vec) else begin
        miscompares++;
        $error("[TB] FAIL %s: observed %b expected %b", e.tag, obs, e.vec);
      end
    end
  endtask

  task automatic runExpect(input string tag, input int n, input logic [6:0] vec);
    for (int i = 0; i < n; i++) pushExpect(tag, vec);
    for (int i = 0; i < n; i++) begin
      cycle();
      checkOutput();
    end
  endtask

  initial begin
    logic [6:0] v;

    // Reset with buttons pressed and RUN requested: everything stays low
    applyStimulus(2'b11, 1'b1, 1'b0);
    runExpect("reset", 3, 7'b00_00_00_0);

    // Release: first cycles after reset are quiet (debounce and mode sync in progress)
    applyStimulus(2'b11, 1'b1, 1'b1);
    runExpect("post_release", 5, 7'b00_00_00_0);

    // Reset again mid-count: the pending press and RUN tick are abandoned
    applyStimulus(2'b00, 1'b0, 1'b0);
    runExpect("mid_reset", 2, 7'b00_00_00_0);
    applyStimulus(2'b00, 1'b0, 1'b1);
    runExpect("abort_idle", 12, 7'b00_00_00_0);

    // STEP press on channel 0: level, rise and clk_en nine edges later
    applyStimulus(2'b01, 1'b0, 1'b1);
    runExpect("press_wait", 9, 7'b00_00_00_0);
    runExpect("press_rise", 1, 7'b01_01_00_1);
    runExpect("press_hold", 3, 7'b01_00_00_0);

    // Release channel 0: fall nine edges later, no clk_en
    applyStimulus(2'b00, 1'b0, 1'b1);
    runExpect("release_wait", 9, 7'b01_00_00_0);
    runExpect("release_fall", 1, 7'b00_00_01_0);
    runExpect("release_idle", 2, 7'b00_00_00_0);

    // Bounce with three-cycle pulses never reaches level
    applyStimulus(2'b01, 1'b0, 1'b1);
    runExpect("bounce", 3, 7'b00_00_00_0);
    applyStimulus(2'b00, 1'b0, 1'b1);
    runExpect("bounce", 3, 7'b00_00_00_0);
    applyStimulus(2'b01, 1'b0, 1'b1);
    runExpect("bounce", 3, 7'b00_00_00_0);
    applyStimulus(2'b00, 1'b0, 1'b1);
    runExpect("bounce_settle", 20, 7'b00_00_00_0);

    // RUN mode: clk_en every fourth cycle after the state change
    applyStimulus(2'b00, 1'b1, 1'b1);
    runExpect("run_pre", 5, 7'b00_00_00_0);
    runExpect("run_tick", 1, 7'b00_00_00_1);
    runExpect("run_gap", 3, 7'b00_00_00_0);
    runExpect("run_tick", 1, 7'b00_00_00_1);
    runExpect("run_gap", 3, 7'b00_00_00_0);
    runExpect("run_tick", 1, 7'b00_00_00_1);

    // Back to STEP: no further clk_en
    applyStimulus(2'b00, 1'b0, 1'b1);
    runExpect("step_return", 10, 7'b00_00_00_0);

    // Both channels pressed together, then released together
    applyStimulus(2'b11, 1'b0, 1'b1);
    runExpect("both_wait", 9, 7'b00_00_00_0);
    runExpect("both_rise", 1, 7'b11_11_00_1);
    runExpect("both_hold", 2, 7'b11_00_00_0);
    applyStimulus(2'b00, 1'b0, 1'b1);
    runExpect("both_rel_wait", 9, 7'b11_00_00_0);
    runExpect("both_fall", 1, 7'b00_00_11_0);
    runExpect("both_idle", 2, 7'b00_00_00_0);

    // Long hold on channel 0: single clk_en, or repeats when auto-repeat is built in
    applyStimulus(2'b01, 1'b0, 1'b1);
    runExpect("hold_wait", 9, 7'b00_00_00_0);
    for (int d = 0; d <= 74; d++) begin
      v[6:5] = (d < 70) ? 2'b01 : 2'b00;
      v[4:3] = (d == 0) ? 2'b01 : 2'b00;
      v[2:1] = (d == 70) ? 2'b01 : 2'b00;
      v[0]   = (d == 0) ||
               (REPEAT_ON && (d >= 32) && (d < 70) && (((d - 32) % 8) == 0));
      pushExpect("hold", v);
      cycle();
      checkOutput();
      if (d == 60) applyStimulus(2'b00, 1'b0, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
